uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the successor to the fixed 8-bit oversampled receiver.
- Frame format: configurable data width and oversampling ratio.
- Runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
- Reports parity, framing and overrun errors.
- Delivers each received word over a valid/ready handshake to the downstream consumer (FIFO or CPU interface).
- Sits between the baud-rate tick generator and the RX FIFO.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, tick pulses per bit period; even, >=4 (>=8 when UART_RX_MAJORITY_EN is defined).
CNT_W, $clog2(OVERSAMPLE), width of the tick counter (derived).
N_W, $clog2(DATA_BITS), width of the bit counter (derived).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk strobe, OVERSAMPLE pulses per bit
rx  input  1  serial line, asynchronous, idle high
parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none)
stop_bits  input  1  0 = one stop bit, 1 = two stop bits
d_out  output  DATA_BITS  received word, LSB first on the line
parity_err  output  1  parity error for the word on d_out
frame_err  output  1  a stop bit was sampled low for the word on d_out
rx_valid  output  1  d_out, parity_err and frame_err are valid
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
overrun  output  1  sticky: a completed frame was dropped
busy  output  1  high in every state except IDLE

Behaviour:
Reset:
- Asynchronous. Forces state=IDLE and clears all counters and the shift register.
- Outputs: d_out=0, parity_err=0, frame_err=0, rx_valid=0, overrun=0, busy=0.
- The synchronizer flops reset to 1.
- A reset mid-frame discards the partial frame.

Input synchronization:
- rx passes through a 2-FF synchronizer.
- All state logic uses rx_s, which lags rx by 2 clk.

State machine: IDLE, START, DATA, PARITY, STOP. All counting advances only on cycles with tick=1.
- IDLE: rx_s==0 → START with s=0. Latch parity_mode and stop_bits into internal config registers; mid-frame input changes are ignored.
- START: at s==OVERSAMPLE/2-1, sample rx_s.
  - Sample 0 → DATA with s=0, n=0.
  - Sample 1 → IDLE (glitch rejected; nothing reported).
- DATA: at s==OVERSAMPLE-1, shift in: shreg={rx_s, shreg[DATA_BITS-1:1]}, then s=0.
  - After bit n==DATA_BITS-1 → PARITY if latched mode is 01 or 10, else STOP.
  - Otherwise n=n+1.
- PARITY: at s==OVERSAMPLE-1:
  - even mode: perr = ^shreg ^ rx_s
  - odd mode: perr = ~(^shreg ^ rx_s)
  - → STOP with s=0, k=0.
- STOP: at s==OVERSAMPLE-1, if rx_s==0 set ferr.
  - If k==latched stop_bits → complete the frame, go IDLE.
  - Otherwise k=k+1, s=0.
  - IDLE is reached at the middle of the last stop bit, so a back-to-back start edge is caught.

Output and handshake rules:
- On frame completion, if the output register is free (rx_valid==0, or a handshake occurs in the same cycle):
  - load d_out, parity_err, frame_err on the next edge;
  - set rx_valid=1.
- Otherwise the frame is dropped, overrun=1, and the output register is unchanged.
- rx_valid stays high until a handshake. The handshake clears rx_valid unless a new frame loads in that same cycle.
- overrun is cleared on the next handshake.
- Handshake and completion in the same cycle: old word is consumed, new word is loaded, rx_valid stays 1, no overrun.
- Counters: s wraps to 0 at each sample point. n never exceeds DATA_BITS-1.

Latency: rx_valid rises 1 clk after the tick at the last stop-bit sample point.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every sample point (start, data, parity, stop) uses a 2-of-3 majority of rx_s.
  - The three samples are taken at ticks s==P-2, P-1 and P, where P is the nominal sample index.
  - A single-tick glitch does not alter the decoded bit.
- Undefined: single sample at P. No majority registers are instantiated.

Decomposition:
- Shared package/header uart_pkg:
  - parity-mode encodings PAR_NONE, PAR_EVEN, PAR_ODD;
  - one-hot state encodings ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (5-bit).
- One sub-module: uart_rx_sync (2-FF synchronizer with reset-to-1).
- Everything else stays in a single module.

Test Plan:
All scenarios use OVERSAMPLE=16, DATA_BITS=8 and tick every 4 clk.
1. Mode 00, 1 stop, send 0xA5 → rx_valid with d_out=0xA5, parity_err=0, frame_err=0; held until rx_ready=1, then rx_valid=0 next clk.
2. Even parity, send 0x03 with parity bit 1 (wrong) → d_out=0x03, parity_err=1. Repeat with odd parity, bit 1 → parity_err=0.
3. 2 stop bits, second stop driven 0 → frame_err=1, d_out still loaded. Next frame 0x5A with valid stops → frame_err=0.
4. Keep rx_ready=0 and send 0x11 then 0x22 → d_out=0x11, overrun=1. Assert rx_ready → overrun=0 and 0x22 is never presented.
5. 3-tick low pulse on idle line → no rx_valid, busy returns to 0 by mid start bit. Assert reset during the DATA bits of 0xFF → all outputs 0, next frame 0x3C received correctly.
6. With UART_RX_MAJORITY_EN, insert a 1-tick high glitch at the sample tick of data bit 2 of 0x00 → d_out=0x00. Without the macro → d_out=0x04.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity-mode
// encodings, the one-hot receiver state encoding and a 2-of-3 vote helper
// (the helper is only called when UART_RX_MAJORITY_EN is defined).
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so the line reads as idle while reset is held.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronisation of the raw line into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampled UART receiver with runtime parity/stop selection,
// parity/framing/overrun reporting and a valid/ready output register.
// Optional macro UART_RX_MAJORITY_EN: every sample point takes a 2-of-3 vote
// over the ticks P-2, P-1 and P instead of a single sample at P.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE),
    parameter int N_W        = $clog2(DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] S_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0]   N_LAST = N_W'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic [CNT_W-1:0]     s_q;
    logic [N_W-1:0]       n_q;
    logic                 k_q;
    logic [1:0]           par_q;
    logic                 stop2_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 perr_q;
    logic                 ferr_q;

    logic [DATA_BITS-1:0] d_out_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 rx_valid_q;
    logic                 overrun_q;

    logic                 rx_s;
    logic                 samp_bit;
    logic [CNT_W-1:0]     samp_pt;
    logic                 has_par;
    logic                 frame_done;
    logic                 ferr_final;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // The start bit is sampled mid-bit; every later bit one full period on
    assign samp_pt = (state_q == ST_START) ? S_HALF : S_LAST;

`ifdef UART_RX_MAJORITY_EN
    logic m0_q;
    logic m1_q;

    // Capture the two early votes just ahead of each nominal sample point
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_q <= 1'b1;
            m1_q <= 1'b1;
        end else if (tick) begin
            if (s_q == samp_pt - CNT_W'(2)) m0_q <= rx_s;
            if (s_q == samp_pt - CNT_W'(1)) m1_q <= rx_s;
        end
    end

    assign samp_bit = maj3(m0_q, m1_q, rx_s);
`else
    assign samp_bit = rx_s;
`endif

    assign has_par    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign frame_done = (state_q == ST_STOP) && tick && (s_q == S_LAST) && (k_q == stop2_q);
    assign ferr_final = ferr_q | ~samp_bit;

    // Frame-level state machine: start detection, bit counting and shifting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            k_q     <= 1'b0;
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                        par_q   <= parity_mode;
                        stop2_q <= stop_bits;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s_q == S_HALF) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            state_q <= samp_bit ? ST_IDLE : ST_DATA;
                        end else begin
                            s_q <= s_q + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            shreg_q <= {samp_bit, shreg_q[DATA_BITS-1:1]};
                            s_q     <= '0;
                            if (n_q == N_LAST) begin
                                k_q     <= 1'b0;
                                state_q <= has_par ? ST_PARITY : ST_STOP;
                            end else begin
                                n_q <= n_q + N_W'(1);
                            end
                        end else begin
                            s_q <= s_q + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            perr_q  <= (par_q == PAR_ODD) ? ~(^shreg_q ^ samp_bit)
                                                          : (^shreg_q ^ samp_bit);
                            s_q     <= '0;
                            k_q     <= 1'b0;
                            state_q <= ST_STOP;
                        end else begin
                            s_q <= s_q + CNT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            if (!samp_bit) ferr_q <= 1'b1;
                            // Returning to idle mid stop bit lets a
                            // back-to-back start edge be caught
                            if (k_q == stop2_q) begin
                                state_q <= ST_IDLE;
                            end else begin
                                k_q <= 1'b1;
                            end
                        end else begin
                            s_q <= s_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (frame_done) begin
                if (!rx_valid_q || rx_ready) begin
                    d_out_q      <= shreg_q;
                    parity_err_q <= perr_q;
                    frame_err_q  <= ferr_final;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign d_out      = d_out_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_valid   = rx_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (OVERSAMPLE=16, DATA_BITS=8, tick
// every 4 clk). Frames are composed bit by bit on the line; the expected
// output register contents come from a frame-level model of the receiver.
module tb_uart_rx_param;

    localparam int DW      = 8;
    localparam int OS      = 16;
    localparam int BIT_CLK = OS * 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          rx = 1'b1;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop_bits = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] d_out;
    logic          parity_err;
    logic          frame_err;
    logic          rx_valid;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // Frame-level model of the output register
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_word = '0;
    logic          m_perr = 1'b0;
    logic          m_ferr = 1'b0;
    logic          m_ovr = 1'b0;

    uart_rx_param #(.DATA_BITS(DW), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .rx          (rx),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .d_out       (d_out),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic check_out(input string tag);
        check_eq({tag, ".rx_valid"},   32'(rx_valid),   32'(m_valid));
        check_eq({tag, ".d_out"},      32'(d_out),      32'(m_word));
        check_eq({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
        check_eq({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
        check_eq({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
    endtask

    task automatic consume(input string tag);
        @(negedge clk) rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check_eq({tag, ".consumed_valid"},   32'(rx_valid), 32'(m_valid));
        check_eq({tag, ".consumed_overrun"}, 32'(overrun),  32'(m_ovr));
    endtask

    // Drives one frame starting just before a tick edge; line index c maps to
    // clock edge T0+c. A low stop bit is held low only for its first 40 clk so
    // the receiver's re-armed start detector sees a clean high line afterwards.
    task automatic send_frame(input logic [DW-1:0] data, input logic [1:0] pmode,
                              input logic pflip, input logic two_stop,
                              input logic [1:0] stop_low, input int glitch_at,
                              input logic hs_on_done);
        logic line [12];
        int   nb;
        int   first_stop;
        int   hs_at;
        logic has_par;
        logic pexp;
        logic lvl;
        parity_mode = pmode;
        stop_bits   = two_stop;
        has_par = (pmode == 2'b01) || (pmode == 2'b10);
        pexp    = (pmode == 2'b10) ? ~(^data) : (^data);
        nb = 0;
        line[nb++] = 1'b0;
        for (int i = 0; i < DW; i++) line[nb++] = data[i];
        if (has_par) line[nb++] = pexp ^ pflip;
        first_stop = nb;
        line[nb++] = ~stop_low[0];
        if (two_stop) line[nb++] = ~stop_low[1];
        hs_at = hs_on_done ? (BIT_CLK / 2 + BIT_CLK * (nb - 1)) : -1;
        @(posedge tick);
        for (int c = 0; c < nb * BIT_CLK; c++) begin
            if (c > 0) @(negedge clk);
            lvl = line[c / BIT_CLK];
            if ((c / BIT_CLK) >= first_stop && !lvl && (c % BIT_CLK) >= 40) lvl = 1'b1;
            if (glitch_at >= 0 && c >= glitch_at && c < glitch_at + 4) lvl = ~lvl;
            rx = lvl;
            if (hs_on_done) rx_ready = (c == hs_at);
            if (c == 100) begin
                parity_mode = 2'($urandom_range(0, 3));
                stop_bits   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        rx = 1'b1;
        if (hs_on_done) rx_ready = 1'b0;
        repeat (16) @(negedge clk);
        if (hs_on_done && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        if (!m_valid) begin
            m_valid = 1'b1;
            m_word  = data;
            m_perr  = has_par & pflip;
            m_ferr  = stop_low[0] | (two_stop & stop_low[1]);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check_out("reset");
        check_eq("reset.busy", 32'(busy), 32'(0));
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // Plain 8N1 frame, held until accepted
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        check_out("a5_8n1");
        repeat (50) @(negedge clk);
        check_eq("a5_hold.rx_valid", 32'(rx_valid), 32'(1));
        consume("a5");

        // Even parity with wrong bit, odd parity with right bit
        send_frame(8'h03, 2'b01, 1'b1, 1'b0, 2'b00, -1, 1'b0);
        check_out("03_even_bad");
        consume("03e");
        send_frame(8'h03, 2'b10, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        check_out("03_odd_good");
        consume("03o");

        // Two stop bits, second low; then a clean frame
        send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 2'b10, -1, 1'b0);
        check_out("c3_stop2_low");
        consume("c3");
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 2'b00, -1, 1'b0);
        check_out("5a_stop2_ok");
        consume("5a");

        // Overrun: second frame dropped while the first is pending
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        check_out("overrun");
        consume("overrun");
        repeat (100) @(negedge clk);
        check_eq("dropped_never_shown", 32'(rx_valid), 32'(0));

        // Handshake in the same cycle as frame completion
        send_frame(8'h77, 2'b00, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        send_frame(8'h88, 2'b01, 1'b0, 1'b0, 2'b00, -1, 1'b1);
        check_out("same_cycle_hs");
        consume("88");

        // Three-tick low pulse on the idle line is rejected
        @(posedge tick);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("glitch.busy_high", 32'(busy), 32'(1));
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch.busy_low", 32'(busy), 32'(0));
        check_eq("glitch.no_valid", 32'(rx_valid), 32'(0));

        // Reset during the data bits of 0xFF
        @(posedge tick);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        reset = 1'b1;
        #1;
        m_valid = 1'b0; m_word = '0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_out("async_reset");
        check_eq("async_reset.busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (BIT_CLK * 10) @(negedge clk);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 2'b00, -1, 1'b0);
        check_out("3c_after_reset");
        consume("3c");

        // One-tick high glitch at the sample point of data bit 2 of 0x00
        send_frame(8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 220, 1'b0);
`ifdef UART_RX_MAJORITY_EN
        check_eq("glitch_bit2.d_out", 32'(d_out), 32'(8'h00));
`else
        check_eq("glitch_bit2.d_out", 32'(d_out), 32'(8'h04));
`endif
        check_eq("glitch_bit2.rx_valid", 32'(rx_valid), 32'(1));
        m_valid = 1'b1; m_word = d_out; m_perr = 1'b0; m_ferr = 1'b0;
        consume("glitch_bit2");

        // Randomized frames against the model
        for (int t = 0; t < 20; t++) begin
            logic [DW-1:0] data;
            logic [1:0]    pm;
            logic [1:0]    sl;
            data = DW'($urandom);
            pm   = 2'($urandom_range(0, 3));
            sl   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            if (m_valid && ($urandom_range(0, 1) == 1)) consume("rand");
            send_frame(data, pm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sl, -1,
                       ($urandom_range(0, 3) == 0));
            check_out($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
